// File: rtl/urv_mem2wb_burst_pkg.sv
// Shared bus configuration, request/response types and bridge FSM states
// for the urv_cpu system bus to Wishbone burst bridge.
package urv_mem2wb_burst_pkg;

  localparam int MEM_ADDR_W    = 32;
  localparam int MEM_DATA_W    = 32;
  localparam int MEM_MASK_W    = 4;
  localparam int BURST_MAX_DEF = 8;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_type_e;

  typedef struct packed {
    mem_type_e               req_type;
    logic [MEM_ADDR_W-1:0]   req_addr;
    logic [MEM_DATA_W-1:0]   req_data;
    logic [MEM_MASK_W-1:0]   req_mask;
    logic [3:0]              req_burst;  // beats-1
  } mem_req_t;

  typedef struct packed {
    logic [MEM_DATA_W-1:0]   resp_data;
    logic                    resp_err;
    logic                    resp_last;
  } mem_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_st_e;

  // Index of the final beat: writes are always single-beat, reads are
  // clamped so a long request never exceeds the configured burst limit.
  function automatic logic [3:0] last_beat_idx(mem_type_e typ, logic [3:0] burst, int burst_max);
    if (typ == MEM_WRITE)
      return 4'd0;
    if (int'(burst) >= burst_max - 1)
      return 4'(burst_max - 1);
    return burst;
  endfunction

endpackage

// File: rtl/urv_wb_watchdog.sv
// Per-beat bus watchdog: fires once a Wishbone beat has waited TIMEOUT_CYC
// cycles without termination. TIMEOUT_CYC=0 removes the timer entirely.
module urv_wb_watchdog #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYC == 0) begin : g_off
    logic unused_in;
    assign unused_in = ^{clk, rst, clear, enable};
    assign expired   = 1'b0;
  end else begin : g_on
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Down-counter reloaded whenever no beat is outstanding; terminal count
    // is reached on the TIMEOUT_CYC-th cycle of an enabled beat.
    always_ff @(posedge clk) begin
      if (rst || clear)
        cnt <= LOAD;
      else if (enable && cnt != '0)
        cnt <= cnt - 1'b1;
    end

    assign expired = enable && !clear && (cnt == '0);
  end

endmodule

// File: rtl/urv_mem2wb_burst.sv
// Bridge from the urv_cpu mem_req/mem_resp handshake to a classic Wishbone
// master with incrementing read bursts, error propagation and a watchdog.
//
// state   | meaning
// IDLE    | ready for a new request
// BUS     | Wishbone beat in flight (cyc/stb high)
// RESP    | beat result presented on mem_resp; cyc kept high mid-burst
module urv_mem2wb_burst
  import urv_mem2wb_burst_pkg::*;
#(
  parameter int BURST_MAX   = BURST_MAX_DEF,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req_valid,
  output logic                  mem_req_ready,
  input  mem_req_t              mem_req,
  output logic                  mem_resp_valid,
  input  logic                  mem_resp_ready,
  output mem_resp_t             mem_resp,
  output logic                  wb_stb_o,
  output logic [MEM_ADDR_W-1:0] wb_addr_o,
  output logic                  wb_we_o,
  output logic [MEM_DATA_W-1:0] wb_data_o,
  output logic [MEM_MASK_W-1:0] wb_sel_o,
  output logic                  wb_cyc_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic [MEM_DATA_W-1:0] wb_data_i
);

  wb_st_e     st;
  logic [3:0] last_idx;
  logic [3:0] beat_cnt;
  logic       wd_expired;
  logic       beat_last;

  urv_wb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (st != ST_BUS),
    .enable (st == ST_BUS),
    .expired(wd_expired)
  );

  assign beat_last = (beat_cnt == last_idx);

  // Bridge FSM; every bus-facing and cpu-facing output is a register here.
  always_ff @(posedge clk) begin
    if (rst) begin
      st             <= ST_IDLE;
      mem_req_ready  <= 1'b0;
      mem_resp_valid <= 1'b0;
      mem_resp       <= '0;
      wb_stb_o       <= 1'b0;
      wb_cyc_o       <= 1'b0;
      wb_addr_o      <= '0;
      wb_we_o        <= 1'b0;
      wb_data_o      <= '0;
      wb_sel_o       <= '0;
      last_idx       <= '0;
      beat_cnt       <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          mem_req_ready <= 1'b1;
          if (mem_req_valid && mem_req_ready) begin
            mem_req_ready <= 1'b0;
            wb_addr_o     <= mem_req.req_addr;
            wb_we_o       <= (mem_req.req_type == MEM_WRITE);
            wb_data_o     <= mem_req.req_data;
            wb_sel_o      <= (mem_req.req_type == MEM_WRITE) ? mem_req.req_mask : '1;
            last_idx      <= last_beat_idx(mem_req.req_type, mem_req.req_burst, BURST_MAX);
            beat_cnt      <= '0;
            wb_cyc_o      <= 1'b1;
            wb_stb_o      <= 1'b1;
            st            <= ST_BUS;
          end
        end
        ST_BUS: begin
          // err (slave or watchdog) outranks ack and abandons the burst
          if (wb_err_i || wd_expired) begin
            mem_resp       <= '{resp_data: '0, resp_err: 1'b1, resp_last: 1'b1};
            mem_resp_valid <= 1'b1;
            wb_stb_o       <= 1'b0;
            wb_cyc_o       <= 1'b0;
            st             <= ST_RESP;
          end else if (wb_ack_i) begin
            mem_resp       <= '{resp_data: wb_we_o ? '0 : wb_data_i,
                                resp_err:  1'b0,
                                resp_last: beat_last};
            mem_resp_valid <= 1'b1;
            wb_stb_o       <= 1'b0;
            wb_cyc_o       <= !beat_last;
            st             <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (mem_resp_ready) begin
            mem_resp_valid <= 1'b0;
            if (mem_resp.resp_last) begin
              mem_req_ready <= 1'b1;
              st            <= ST_IDLE;
            end else begin
              wb_addr_o <= wb_addr_o + MEM_ADDR_W'(MEM_MASK_W);
              beat_cnt  <= beat_cnt + 4'd1;
              wb_stb_o  <= 1'b1;
              st        <= ST_BUS;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_urv_mem2wb_burst.sv
// Randomized scoreboard bench for urv_mem2wb_burst: a request model queues
// expected Wishbone beats and cpu responses, a slave model checks the beats
// and a monitor checks responses as they are handshaken.
module tb_urv_mem2wb_burst;
  import urv_mem2wb_burst_pkg::*;

  localparam int TO   = 16;
  localparam int BMAX = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  mem_req_valid = 1'b0;
  logic                  mem_req_ready;
  mem_req_t              mem_req = '0;
  logic                  mem_resp_valid;
  logic                  mem_resp_ready = 1'b0;
  mem_resp_t             mem_resp;
  logic                  wb_stb_o;
  logic [MEM_ADDR_W-1:0] wb_addr_o;
  logic                  wb_we_o;
  logic [MEM_DATA_W-1:0] wb_data_o;
  logic [MEM_MASK_W-1:0] wb_sel_o;
  logic                  wb_cyc_o;
  logic                  wb_ack_i = 1'b0;
  logic                  wb_err_i = 1'b0;
  logic [MEM_DATA_W-1:0] wb_data_i = '0;

  urv_mem2wb_burst #(.BURST_MAX(BMAX), .TIMEOUT_CYC(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req       (mem_req),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_ready(mem_resp_ready),
    .mem_resp      (mem_resp),
    .wb_stb_o      (wb_stb_o),
    .wb_addr_o     (wb_addr_o),
    .wb_we_o       (wb_we_o),
    .wb_data_o     (wb_data_o),
    .wb_sel_o      (wb_sel_o),
    .wb_cyc_o      (wb_cyc_o),
    .wb_ack_i      (wb_ack_i),
    .wb_err_i      (wb_err_i),
    .wb_data_i     (wb_data_i)
  );

  always #5 clk = ~clk;

  // mode: 0 = ack, 1 = err, 2 = silent slave
  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] data;
    int          mode;
    bit          ack_too;
    int          waits;
    bit          hold;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    bit          err;
    bit          last;
  } rsp_t;

  beat_t bus_q[$];
  rsp_t  exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    n_resp      = 0;
  int    stall_pct   = 0;
  bit    force_stall = 1'b0;
  bit    noise_en    = 1'b0;

  function automatic logic [31:0] slave_word(logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference model: expand a request into its Wishbone beats and responses,
  // then present it on the request port.
  task automatic issue(mem_type_e t, logic [31:0] a, logic [31:0] d, logic [3:0] m,
                       logic [3:0] burst, int err_beat, bit silent,
                       int wlo, int whi, bit ack_too);
    int nb;
    int n;
    nb = (t == MEM_WRITE) ? 1 : ((int'(burst) + 1 > BMAX) ? BMAX : int'(burst) + 1);
    for (int i = 0; i < nb; i++) begin
      beat_t b;
      rsp_t  r;
      b.addr    = a + 32'(4 * i);
      b.we      = (t == MEM_WRITE);
      b.sel     = b.we ? m : 4'hF;
      b.data    = d;
      b.waits   = int'($urandom_range(wlo, whi));
      b.ack_too = ack_too;
      b.mode    = (silent && i == 0) ? 2 : ((i == err_beat) ? 1 : 0);
      r.err     = (b.mode != 0);
      r.last    = r.err || (i == nb - 1);
      r.data    = (r.err || b.we) ? 32'h0 : slave_word(b.addr);
      b.hold    = !r.last;
      bus_q.push_back(b);
      exp_q.push_back(r);
      if (r.err) break;
    end
    @(posedge clk);
    #1;
    mem_req.req_type  = t;
    mem_req.req_addr  = a;
    mem_req.req_data  = d;
    mem_req.req_mask  = m;
    mem_req.req_burst = burst;
    mem_req_valid     = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req_ready && n < 2000);
    if (!mem_req_ready) bound_fail("req_accept");
    @(posedge clk);
    #1;
    mem_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || bus_q.size() != 0) bound_fail("drain");
  endtask

  task automatic chk_idle_outputs(string tag);
    chk({tag, "_ctl"}, 64'({mem_req_ready, mem_resp_valid, wb_stb_o, wb_cyc_o, wb_we_o}), 64'd0);
    chk({tag, "_resp"}, 64'(mem_resp), 64'd0);
    chk({tag, "_addr"}, 64'(wb_addr_o), 64'd0);
    chk({tag, "_wdata"}, 64'(wb_data_o), 64'd0);
    chk({tag, "_sel"}, 64'(wb_sel_o), 64'd0);
  endtask

  // cpu-side response backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_resp_ready = !force_stall && ($urandom_range(0, 99) >= stall_pct);
    end
  end

  // Wishbone slave: checks each beat against the model and terminates it
  initial begin
    beat_t cur;
    bit    in_beat = 1'b0;
    int    stb_cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        in_beat  = 1'b0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
      end else if (wb_stb_o) begin
        if (!in_beat) begin
          in_beat = 1'b1;
          stb_cyc = 0;
          if (bus_q.size() == 0) begin
            bound_fail("bus_unexpected_beat");
            cur = '{addr: wb_addr_o, we: wb_we_o, sel: wb_sel_o, data: wb_data_o,
                    mode: 0, ack_too: 1'b0, waits: 0, hold: 1'b0};
          end else begin
            cur = bus_q.pop_front();
          end
          chk("bus_addr", 64'(wb_addr_o), 64'(cur.addr));
          chk("bus_we", 64'(wb_we_o), 64'(cur.we));
          chk("bus_sel", 64'(wb_sel_o), 64'(cur.sel));
          chk("bus_cyc", 64'(wb_cyc_o), 64'd1);
          if (cur.we) chk("bus_wdata", 64'(wb_data_o), 64'(cur.data));
        end
        stb_cyc++;
        if (cur.mode != 2 && stb_cyc > cur.waits) begin
          wb_ack_i  = (cur.mode == 0) || cur.ack_too;
          wb_err_i  = (cur.mode == 1);
          wb_data_i = slave_word(wb_addr_o);
        end else begin
          wb_ack_i  = 1'b0;
          wb_err_i  = 1'b0;
          wb_data_i = $urandom;
        end
      end else begin
        if (in_beat) begin
          in_beat = 1'b0;
          chk("bus_stb_cycles", 64'(stb_cyc), 64'((cur.mode == 2) ? TO : cur.waits + 1));
          chk("bus_cyc_after_beat", 64'(wb_cyc_o), 64'(cur.hold));
        end
        wb_ack_i  = noise_en && ($urandom_range(0, 3) == 0);
        wb_err_i  = noise_en && ($urandom_range(0, 5) == 0);
        wb_data_i = $urandom;
      end
    end
  end

  // Response monitor: stability under stall and scoreboard compare on handshake
  initial begin
    rsp_t      e;
    bit        pv = 1'b0;
    bit        pr = 1'b0;
    mem_resp_t pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (mem_resp_valid && pv && !pr)
          chk("resp_stable", 64'(mem_resp), 64'(pd));
        if (mem_resp_valid && mem_resp_ready) begin
          if (exp_q.size() == 0) begin
            bound_fail("resp_unexpected");
          end else begin
            e = exp_q.pop_front();
            chk("resp_data", 64'(mem_resp.resp_data), 64'(e.data));
            chk("resp_err", 64'(mem_resp.resp_err), 64'(e.err));
            chk("resp_last", 64'(mem_resp.resp_last), 64'(e.last));
          end
          n_resp++;
        end
        pv = mem_resp_valid;
        pr = mem_resp_ready;
        pd = mem_resp;
      end
    end
  end

  initial begin
    int n;
    int base;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;

    // single read with two wait states
    issue(MEM_READ, 32'h8000_0010, 32'h0, 4'h0, 4'd0, -1, 1'b0, 2, 2, 1'b0);
    drain();
    // write ignores req_burst
    issue(MEM_WRITE, 32'h0000_1000, 32'h1234_5678, 4'b0011, 4'd5, -1, 1'b0, 0, 1, 1'b0);
    drain();
    // 4-beat burst, zero-wait, with backpressure
    stall_pct = 50;
    issue(MEM_READ, 32'h0000_0100, 32'h0, 4'h0, 4'd3, -1, 1'b0, 0, 0, 1'b0);
    drain();
    stall_pct = 0;
    // err together with ack on beat 2
    issue(MEM_READ, 32'h0000_0100, 32'h0, 4'h0, 4'd3, 2, 1'b0, 0, 0, 1'b1);
    drain();
    // address wrap and length clamp
    issue(MEM_READ, 32'hFFFF_FFF8, 32'h0, 4'h0, 4'd3, -1, 1'b0, 0, 1, 1'b0);
    issue(MEM_READ, 32'h0000_0200, 32'h0, 4'h0, 4'd15, -1, 1'b0, 0, 1, 1'b0);
    drain();
    // silent slave then an immediate follow-up request
    issue(MEM_READ, 32'h0000_0300, 32'h0, 4'h0, 4'd2, -1, 1'b1, 0, 0, 1'b0);
    issue(MEM_READ, 32'h0000_0304, 32'h0, 4'h0, 4'd0, -1, 1'b0, 0, 0, 1'b0);
    drain();

    // reset while the second beat of a 4-beat burst is stalled in RESP
    base = n_resp;
    issue(MEM_READ, 32'h0000_0400, 32'h0, 4'h0, 4'd3, -1, 1'b0, 0, 0, 1'b0);
    n = 0;
    while (n_resp < base + 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n_resp < base + 1) bound_fail("reset_wait_beat0");
    force_stall = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_resp_valid && !mem_resp_ready) && n < 200);
    if (!(mem_resp_valid && !mem_resp_ready)) bound_fail("reset_wait_beat1");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_idle_outputs("midrst");
    rst = 1'b0;
    exp_q.delete();
    bus_q.delete();
    force_stall = 1'b0;
    repeat (20) @(negedge clk);
    issue(MEM_READ, 32'h0000_0500, 32'h0, 4'h0, 4'd1, -1, 1'b0, 0, 2, 1'b0);
    drain();

    // randomized traffic with spurious ack/err while stb is low
    noise_en  = 1'b1;
    stall_pct = 30;
    for (int k = 0; k < 60; k++) begin
      mem_type_e t;
      int        eb;
      t  = ($urandom_range(0, 1) != 0) ? MEM_WRITE : MEM_READ;
      eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
      issue(t, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), eb, ($urandom_range(0, 14) == 0),
            0, 3, ($urandom_range(0, 1) != 0));
    end
    drain();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
